// File: rtl/wiggle_seq_pkg.sv
// rtl/wiggle_seq_pkg.sv - states, phase constants and phase-order helper for wiggle_seq
package wiggle_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WALK,
        ST_TOGGLE,
        ST_COUNT,
        ST_DONE
    } state_e;

    localparam int PH_WALK   = 0;
    localparam int PH_TOGGLE = 1;
    localparam int PH_COUNT  = 2;

    localparam int GPIO_W_DEF   = 32;
    localparam int WALK_STEPS   = GPIO_W_DEF;
    localparam int TOGGLE_STEPS = 16;
    localparam int COUNT_STEPS  = 256;

    localparam logic [31:0] TOGGLE_PAT_EVEN = 32'hAAAA_AAAA;
    localparam logic [31:0] TOGGLE_PAT_ODD  = 32'h5555_5555;

    // Next enabled phase after cur; ST_IDLE as input yields the first enabled phase.
    function automatic state_e next_phase(input state_e cur, input logic [2:0] mask);
        next_phase = ST_DONE;
        case (cur)
            ST_IDLE: begin
                if (mask[PH_WALK])        next_phase = ST_WALK;
                else if (mask[PH_TOGGLE]) next_phase = ST_TOGGLE;
                else if (mask[PH_COUNT])  next_phase = ST_COUNT;
            end
            ST_WALK: begin
                if (mask[PH_TOGGLE])      next_phase = ST_TOGGLE;
                else if (mask[PH_COUNT])  next_phase = ST_COUNT;
            end
            ST_TOGGLE: begin
                if (mask[PH_COUNT])       next_phase = ST_COUNT;
            end
            default: next_phase = ST_DONE;
        endcase
    endfunction

endpackage

// File: rtl/wiggle_seq_if.sv
// rtl/wiggle_seq_if.sv - start/busy/done handshake and GPIO bank bundle
interface wiggle_seq_if #(
    parameter int GPIO_W  = 32,
    parameter int DWELL_W = 16
);
    logic               start;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         mode_mask;
    logic               busy;
    logic               done;
    logic [7:0]         step_idx;
    logic [GPIO_W-1:0]  gpio_a;
    logic [GPIO_W-1:0]  gpio_b;

    modport master (
        output start, dwell, mode_mask,
        input  busy, done, step_idx, gpio_a, gpio_b
    );

    modport slave (
        input  start, dwell, mode_mask,
        output busy, done, step_idx, gpio_a, gpio_b
    );
endinterface

// File: rtl/wiggle_dwell_timer.sv
// rtl/wiggle_dwell_timer.sv - step_tick every max(dwell,1) cycles after clear
module wiggle_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               osc,
    input  logic               perstn,
    input  logic               clear,
    input  logic [DWELL_W-1:0] dwell,
    output logic               step_tick
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] last_cnt;

    // A dwell of zero behaves as one, so the last count is never below zero.
    assign last_cnt  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign step_tick = !clear && (cnt_q == last_cnt);

    always_ff @(posedge osc or negedge perstn) begin
        if (!perstn) begin
            cnt_q <= '0;
        end else if (clear || step_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/wiggle_seq.sv
// rtl/wiggle_seq.sv - GPIO walk/toggle/count pattern sequencer; WIGGLE_SEQ_LOOP_EN enables back-to-back passes
module wiggle_seq
    import wiggle_seq_pkg::*;
#(
    parameter int GPIO_W  = WALK_STEPS,
    parameter int DWELL_W = 16
) (
    input  logic        osc,
    input  logic        perstn,
    wiggle_seq_if.slave bus
);

    state_e             state_q;
    state_e             state_d;
    logic [7:0]         step_q;
    logic [7:0]         step_d;
    logic [DWELL_W-1:0] dwell_q;
    logic [2:0]         mask_q;
    logic               accept;
    logic               loop_done;
    logic               is_last;
    logic               step_tick;
    logic               timer_clear;
    logic [GPIO_W-1:0]  pat_a;
    logic [GPIO_W-1:0]  pat_b;

    assign timer_clear = (state_q == ST_IDLE) || (state_q == ST_DONE);

    wiggle_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .osc       (osc),
        .perstn    (perstn),
        .clear     (timer_clear),
        .dwell     (dwell_q),
        .step_tick (step_tick)
    );

    always_comb begin
        is_last = 1'b0;
        case (state_q)
            ST_WALK:   is_last = (step_q == 8'(GPIO_W - 1));
            ST_TOGGLE: is_last = (step_q == 8'(TOGGLE_STEPS - 1));
            ST_COUNT:  is_last = (step_q == 8'(COUNT_STEPS - 1));
            default:   is_last = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        accept    = 1'b0;
        loop_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = next_phase(ST_IDLE, bus.mode_mask);
                    step_d  = 8'd0;
                end
            end
            ST_WALK, ST_TOGGLE, ST_COUNT: begin
                if (step_tick) begin
                    if (is_last) begin
                        step_d  = 8'd0;
                        state_d = next_phase(state_q, mask_q);
`ifdef WIGGLE_SEQ_LOOP_EN
                        // Restart straight into the next pass; done overlaps its first step.
                        if (state_d == ST_DONE && bus.start) begin
                            state_d   = next_phase(ST_IDLE, mask_q);
                            loop_done = 1'b1;
                        end
`endif
                    end else begin
                        step_d = step_q + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                step_d  = 8'd0;
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = 8'd0;
            end
        endcase
    end

    // Patterns are decoded from next state so the output flops show the step in its first cycle.
    always_comb begin
        pat_a = '0;
        pat_b = '0;
        case (state_d)
            ST_WALK: begin
                pat_a = GPIO_W'(1) << step_d;
                pat_b = ~pat_a;
            end
            ST_TOGGLE: begin
                pat_a = step_d[0] ? GPIO_W'(TOGGLE_PAT_ODD) : GPIO_W'(TOGGLE_PAT_EVEN);
                pat_b = ~pat_a;
            end
            ST_COUNT: begin
                pat_a = GPIO_W'(step_d);
                for (int i = 0; i < GPIO_W; i++) begin
                    pat_b[i] = pat_a[GPIO_W-1-i];
                end
            end
            default: begin
                pat_a = '0;
                pat_b = '0;
            end
        endcase
    end

    always_ff @(posedge osc or negedge perstn) begin
        if (!perstn) begin
            state_q      <= ST_IDLE;
            step_q       <= 8'd0;
            dwell_q      <= '0;
            mask_q       <= 3'b000;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.step_idx <= 8'd0;
            bus.gpio_a   <= '0;
            bus.gpio_b   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            if (accept) begin
                dwell_q <= bus.dwell;
                mask_q  <= bus.mode_mask;
            end
            bus.busy     <= (state_d != ST_IDLE);
            bus.done     <= (state_d == ST_DONE) || loop_done;
            bus.step_idx <= step_d;
            bus.gpio_a   <= pat_a;
            bus.gpio_b   <= pat_b;
        end
    end

endmodule

// File: tb/tb_wiggle_seq.sv
// tb/tb_wiggle_seq.sv - directed self-checking bench for wiggle_seq
module tb_wiggle_seq;

    logic osc;
    logic perstn;
    int   tests;
    int   fails;

    wiggle_seq_if #(.GPIO_W(32), .DWELL_W(16)) bus ();

    wiggle_seq #(.GPIO_W(32), .DWELL_W(16)) dut (
        .osc    (osc),
        .perstn (perstn),
        .bus    (bus)
    );

    initial osc = 1'b0;
    always #5 osc = ~osc;

    task automatic tick();
        @(posedge osc);
        #1;
    endtask

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    task automatic check_idle_outputs(input string name);
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.step_idx !== 8'd0 ||
            bus.gpio_a !== 32'd0 || bus.gpio_b !== 32'd0) begin
            fails++;
            $display("FAIL %s: busy=%b done=%b step=%0d a=%h b=%h, required all zero",
                     name, bus.busy, bus.done, bus.step_idx, bus.gpio_a, bus.gpio_b);
        end
    endtask

    task automatic pulse_reset();
        perstn = 1'b0;
        #1;
        perstn = 1'b1;
    endtask

    task automatic test_reset();
        perstn = 1'b0;
        bus.start = 1'b1;
        bus.mode_mask = 3'b001;
        bus.dwell = 16'd1;
        #100;
        check_idle_outputs("reset_hold");
        tick();
        perstn = 1'b1;
        check_idle_outputs("reset_release");
        tick();
        tests++;
        if (bus.busy !== 1'b1 || bus.gpio_a !== 32'h1 || bus.step_idx !== 8'd0) begin
            fails++;
            $display("FAIL reset_first_step: busy=%b a=%h step=%0d, required busy=1 a=00000001 step=0",
                     bus.busy, bus.gpio_a, bus.step_idx);
        end
        bus.start = 1'b0;
        pulse_reset();
        check_idle_outputs("reset_cleanup");
    endtask

    task automatic test_walk();
        logic [31:0] exp_a;
        int s;
        bus.mode_mask = 3'b001;
        bus.dwell = 16'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.dwell = 16'd5;
        bus.mode_mask = 3'b111;
        for (int c = 1; c <= 64; c++) begin
            s = (c - 1) / 2;
            exp_a = 32'h1 << s;
            tests++;
            if (bus.gpio_a !== exp_a || bus.gpio_b !== ~exp_a || bus.step_idx !== 8'(s) ||
                bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                fails++;
                if (fails < 20)
                    $display("FAIL walk c%0d: a=%h b=%h step=%0d busy=%b done=%b, required a=%h b=%h step=%0d busy=1 done=0",
                             c, bus.gpio_a, bus.gpio_b, bus.step_idx, bus.busy, bus.done, exp_a, ~exp_a, s);
            end
            tick();
        end
        tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.gpio_a !== 32'd0 || bus.gpio_b !== 32'd0) begin
            fails++;
            $display("FAIL walk_done c65: done=%b busy=%b a=%h b=%h, required done=1 busy=1 a=0 b=0",
                     bus.done, bus.busy, bus.gpio_a, bus.gpio_b);
        end
        tick();
        check_idle_outputs("walk_idle c66");
    endtask

    task automatic test_all_phases();
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        int s;
        bus.mode_mask = 3'b111;
        bus.dwell = 16'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 304; c++) begin
            s = c - 1;
            if (s < 32) begin
                exp_a = 32'h1 << s;
                exp_b = ~exp_a;
            end else if (s < 48) begin
                exp_a = ((s - 32) % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
                exp_b = ~exp_a;
            end else begin
                exp_a = 32'(s - 48);
                exp_b = bitrev(exp_a);
            end
            tests++;
            if (bus.gpio_a !== exp_a || bus.gpio_b !== exp_b || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                fails++;
                if (fails < 20)
                    $display("FAIL all c%0d: a=%h b=%h busy=%b done=%b, required a=%h b=%h busy=1 done=0",
                             c, bus.gpio_a, bus.gpio_b, bus.busy, bus.done, exp_a, exp_b);
            end
            if (c == 50) begin
                tests++;
                if (bus.gpio_a !== 32'h1 || bus.gpio_b !== 32'h8000_0000 || bus.step_idx !== 8'd1) begin
                    fails++;
                    $display("FAIL count_step1: a=%h b=%h step=%0d, required a=00000001 b=80000000 step=1",
                             bus.gpio_a, bus.gpio_b, bus.step_idx);
                end
            end
            tick();
        end
        tests++;
        if (bus.done !== 1'b1 || bus.gpio_a !== 32'd0) begin
            fails++;
            $display("FAIL all_done c305: done=%b a=%h, required done=1 a=0", bus.done, bus.gpio_a);
        end
        tick();
        check_idle_outputs("all_idle c306");
    endtask

    task automatic test_mask_zero();
        bus.mode_mask = 3'b000;
        bus.dwell = 16'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.gpio_a !== 32'd0 || bus.gpio_b !== 32'd0) begin
            fails++;
            $display("FAIL mask0_done: done=%b busy=%b a=%h b=%h, required done=1 busy=1 a=0 b=0",
                     bus.done, bus.busy, bus.gpio_a, bus.gpio_b);
        end
        tick();
        check_idle_outputs("mask0_idle");
    endtask

    task automatic test_abort();
        bus.mode_mask = 3'b111;
        bus.dwell = 16'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (39) tick();
        tests++;
        if (bus.gpio_a !== 32'h5555_5555 || bus.step_idx !== 8'd7) begin
            fails++;
            $display("FAIL abort_pre c40: a=%h step=%0d, required a=55555555 step=7",
                     bus.gpio_a, bus.step_idx);
        end
        #3;
        perstn = 1'b0;
        #1;
        check_idle_outputs("abort_async");
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL abort_hold %0d: done=%b busy=%b, required done=0 busy=0",
                         i, bus.done, bus.busy);
            end
        end
        bus.start = 1'b1;
        perstn = 1'b1;
        tick();
        tests++;
        if (bus.busy !== 1'b1 || bus.step_idx !== 8'd0 || bus.gpio_a !== 32'h1 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL abort_restart: busy=%b step=%0d a=%h done=%b, required busy=1 step=0 a=00000001 done=0",
                     bus.busy, bus.step_idx, bus.gpio_a, bus.done);
        end
        bus.start = 1'b0;
        pulse_reset();
        check_idle_outputs("abort_cleanup");
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a;
        logic        exp_busy;
        logic        exp_done;
        int          exp_step;
        int          last_c;
`ifdef WIGGLE_SEQ_LOOP_EN
        last_c = 50;
`else
        last_c = 36;
`endif
        bus.mode_mask = 3'b010;
        bus.dwell = 16'd1;
        bus.start = 1'b1;
        tick();
        for (int c = 1; c <= last_c; c++) begin
            exp_a = 32'd0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_step = 0;
`ifdef WIGGLE_SEQ_LOOP_EN
            if (c <= 48) begin
                exp_step = (c - 1) % 16;
                exp_a = (exp_step % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
                exp_busy = 1'b1;
                exp_done = (c == 17 || c == 33);
            end else if (c == 49) begin
                exp_busy = 1'b1;
                exp_done = 1'b1;
            end
            if (c == 34) bus.start = 1'b0;
`else
            if (c <= 16 || (c >= 19 && c <= 34)) begin
                exp_step = (c <= 16) ? c - 1 : c - 19;
                exp_a = (exp_step % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
                exp_busy = 1'b1;
            end else if (c == 17 || c == 35) begin
                exp_busy = 1'b1;
                exp_done = 1'b1;
            end
            if (c == 19) bus.start = 1'b0;
`endif
            tests++;
            if (bus.gpio_a !== exp_a || bus.gpio_b !== ((exp_a == 32'd0) ? 32'd0 : ~exp_a) ||
                bus.busy !== exp_busy || bus.done !== exp_done || bus.step_idx !== 8'(exp_step)) begin
                fails++;
                if (fails < 20)
                    $display("FAIL b2b c%0d: a=%h busy=%b done=%b step=%0d, required a=%h busy=%b done=%b step=%0d",
                             c, bus.gpio_a, bus.busy, bus.done, bus.step_idx, exp_a, exp_busy, exp_done, exp_step);
            end
            tick();
        end
        bus.start = 1'b0;
        pulse_reset();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        perstn = 1'b0;
        bus.start = 1'b0;
        bus.dwell = 16'd0;
        bus.mode_mask = 3'b000;
        test_reset();
        test_walk();
        test_all_phases();
        test_mask_zero();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wiggle_seq.md
# wiggle_seq

GPIO pattern sequencer for the wiggle design: it drives the two 32-bit GPIO banks (`gpio_a`, `gpio_b`) through a fixed series of test-pattern phases (walking-one, alternating toggle, binary count). Each pattern step is held for a programmable dwell time. It sits between the board-level `osc`/`perstn` domain and the GPIO pins, and is started and monitored through a simple start/busy/done handshake.

## Interface
- `GPIO_W`, 32, width of each GPIO bank
- `DWELL_W`, 16, width of the dwell (cycles-per-step) input
- `osc`  in  1  system clock
- `perstn`  in  1  reset; asynchronous, active-low, clears all state
- `start`  in  1  level; sampled in IDLE to begin a pass
- `dwell`  in  DWELL_W  cycles each step is held; 0 treated as 1
- `mode_mask`  in  3  phase enables: bit0 WALK, bit1 TOGGLE, bit2 COUNT
- `busy`  out  1  high while a pass is in progress
- `done`  out  1  one-cycle pulse at end of pass
- `step_idx`  out  8  index of current step within the current phase
- `gpio_a`  out  GPIO_W  bank A pattern
- `gpio_b`  out  GPIO_W  bank B pattern

## Operation
- States: IDLE, WALK, TOGGLE, COUNT, DONE.
- IDLE: all outputs 0. When `start`=1, latch `dwell` and `mode_mask`, then go to the first enabled phase in the order WALK, TOGGLE, COUNT.
- If `mode_mask`=0, go straight to DONE.
- WALK: GPIO_W steps.
  - `gpio_a` = 1<<`step_idx`.
  - `gpio_b` = ~`gpio_a`.
- TOGGLE: 16 steps.
  - Even steps: `gpio_a` = 0xAAAA_AAAA.
  - Odd steps: `gpio_a` = 0x5555_5555.
  - `gpio_b` = ~`gpio_a`.
- COUNT: 256 steps.
  - `gpio_a` = zero-extended `step_idx`.
  - `gpio_b` = `gpio_a` bit-reversed across GPIO_W (step 1 gives `gpio_b` = 0x8000_0000).
- After the last step of a phase, go to the next enabled phase with `step_idx` reset to 0. After the last enabled phase, go to DONE.
- DONE: lasts one cycle; `done`=1, `busy`=1, GPIO outputs 0. Then return to IDLE.
- `start` while busy: ignored. Changes to `dwell`/`mode_mask` while busy: ignored; only the values latched at acceptance are used.
- Reset mid-pass: immediate (asynchronous) return to IDLE, all outputs 0, no `done` pulse.

## Timing
- Reset values: `busy`=0, `done`=0, `step_idx`=0, `gpio_a`=0, `gpio_b`=0.
- All outputs are registered.
- First pattern is visible on the cycle after the edge that samples `start`; `busy` rises on that same cycle.
- Each step is held exactly max(`dwell`,1) cycles.
- Pass length in cycles: (sum of enabled phase steps) × max(`dwell`,1), plus 1 for DONE.
- `busy` falls on the cycle after DONE.
- `start` held high through DONE starts a new pass on the cycle after DONE, i.e. after one IDLE cycle with outputs 0.
- Dwell counter width is DWELL_W with no wrap: counts 0..max(`dwell`,1)-1.
- `step_idx` wraps only via the per-phase reset.

## Configuration
- Macro: `WIGGLE_SEQ_LOOP_EN`.
- Defined:
  - On the last step of the last enabled phase, `start` is sampled.
  - If `start`=1, `done` pulses for one cycle concurrent with the first step of the next pass. The pass restarts at the first enabled phase with no DONE state and no IDLE gap, and `busy` stays high.
  - If `start`=0, go to DONE as normal.
- Not defined: one-shot behaviour only. `start` is not examined until IDLE.

## Structure
- Package `wiggle_seq_pkg`:
  - state enum
  - mask bit positions (`PH_WALK`=0, `PH_TOGGLE`=1, `PH_COUNT`=2)
  - step counts (`WALK_STEPS`=GPIO_W, `TOGGLE_STEPS`=16, `COUNT_STEPS`=256)
  - `TOGGLE_PAT_EVEN`=0xAAAA_AAAA, `TOGGLE_PAT_ODD`=0x5555_5555
- Sub-module `wiggle_dwell_timer`:
  - Inputs: `osc`, `perstn`, `clear`, latched dwell.
  - Output: `step_tick`, a one-cycle pulse asserted every max(dwell,1) cycles after `clear`.
  - FSM, `step_idx` and pattern logic stay in `wiggle_seq`.

## Test plan
- Reset: hold `perstn`=0 for 100 ns with `start`=1 → all outputs 0 and `busy`=0. Release → `busy`=1 one cycle after the first sampling edge.
- WALK only: `mode_mask`=3'b001, `dwell`=2 → `gpio_a` steps 0x1, 0x2, …, 0x8000_0000, each for 2 cycles, with `gpio_b` the complement. `done` pulses at cycle 65. `busy` is low at cycle 66.
- All phases, `dwell`=0: 304 steps of 1 cycle each → TOGGLE alternates 0xAAAA_AAAA/0x5555_5555. COUNT step 1 gives `gpio_a`=0x1 and `gpio_b`=0x8000_0000. `done` pulses at cycle 305.
- `mode_mask`=0 → `done` pulses on the cycle after start acceptance; GPIO outputs stay 0 throughout.
- Abort: assert `perstn`=0 mid-TOGGLE → outputs 0 asynchronously, no `done`. After release with `start`=1, the pass restarts at WALK step 0.
- Loop (`WIGGLE_SEQ_LOOP_EN`): `mode_mask`=3'b010, `dwell`=1, `start` held high → `done` pulses every 16 cycles and `busy` stays high. Drop `start` → DONE follows the final step of the current pass.
